// File: rtl/bram_rr_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous
// block RAM. Requests use a valid/ready handshake; read data returns on a
// per-requester strobe RD_LATENCY cycles after the accepting edge.
// RD_LATENCY must be 1..4 and match the attached memory's read pipeline.
module bram_rr_port_arbiter #(
  parameter int ABITS      = 10,
  parameter int DBITS      = 36,
  parameter int RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic             a_we,
  input  logic [ABITS-1:0] a_addr,
  input  logic [DBITS-1:0] a_wdata,
  output logic             a_rvalid,
  output logic [DBITS-1:0] a_rdata,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic             b_we,
  input  logic [ABITS-1:0] b_addr,
  input  logic [DBITS-1:0] b_wdata,
  output logic             b_rvalid,
  output logic [DBITS-1:0] b_rdata,
  output logic             mem_en,
  output logic             mem_we,
  output logic [ABITS-1:0] mem_addr,
  output logic [DBITS-1:0] mem_wd,
  input  logic [DBITS-1:0] mem_rd
);

  // 0 = A granted last, 1 = B granted last
  logic last_grant;
  logic gnt_a, gnt_b;
  logic rd_issue;

  // Response pipeline: stage i holds the request accepted i edges ago
  logic [RD_LATENCY:1] vld_pipe;
  logic [RD_LATENCY:1] id_pipe;

  // Grant selection: lone requester wins, contention goes to the one not served last
  always_comb begin
    gnt_a = 1'b0;
    gnt_b = 1'b0;
    if (rst_n) begin
      if (a_valid && b_valid) begin
        gnt_a = last_grant;
        gnt_b = ~last_grant;
      end else begin
        gnt_a = a_valid;
        gnt_b = b_valid;
      end
    end
  end

  assign a_ready  = gnt_a;
  assign b_ready  = gnt_b;
  assign rd_issue = mem_en & ~mem_we;

  // RAM drive follows the granted request; A's inputs pass through when idle
  always_comb begin
    mem_en   = gnt_a | gnt_b;
    mem_we   = gnt_b ? b_we : (gnt_a & a_we);
    mem_addr = gnt_b ? b_addr : a_addr;
    mem_wd   = gnt_b ? b_wdata : a_wdata;
  end

  // Remember who was served; every grant counts, contended or not
  always_ff @(posedge clk) begin
    if (!rst_n)     last_grant <= 1'b1;
    else if (gnt_a) last_grant <= 1'b0;
    else if (gnt_b) last_grant <= 1'b1;
  end

  // Shift read tags alongside the RAM's read pipeline; reset drops in-flight reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe[1] <= rd_issue;
      id_pipe[1]  <= gnt_b;
      for (int i = 2; i <= RD_LATENCY; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        id_pipe[i]  <= id_pipe[i-1];
      end
    end
  end

  // Gating with rst_n keeps strobes low during reset even before the pipe clears
  assign a_rvalid = rst_n & vld_pipe[RD_LATENCY] & ~id_pipe[RD_LATENCY];
  assign b_rvalid = rst_n & vld_pipe[RD_LATENCY] &  id_pipe[RD_LATENCY];
  assign a_rdata  = mem_rd;
  assign b_rdata  = mem_rd;

endmodule

// File: tb/tb_bram_rr_port_arbiter.sv
// Bench: three arbiter instances (RD_LATENCY 1,2,3), each with its own RAM
// model, share one directed stimulus stream. Expected read responses are
// queued per instance at issue time and checked by a separate monitor.
module tb_bram_rr_port_arbiter;
  localparam int NI = 3;

  typedef struct {
    bit          id;
    logic [35:0] data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [9:0]  a_addr = '0, b_addr = '0;
  logic [35:0] a_wdata = '0, b_wdata = '0;

  logic [NI-1:0] ar, br, arv, brv, men, mwe;
  logic [NI-1:0][9:0]  maddr;
  logic [NI-1:0][35:0] mwd, ard, brd, mrd;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  exp_t qs[NI][$];
  logic [35:0] shadow [0:1023];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int LAT = g + 1;
    logic [35:0] mem  [0:1023];
    logic [35:0] pipe [0:LAT-1];

    initial for (int i = 0; i < 1024; i++) mem[i] = 36'h100 + 36'(i);

    always @(posedge clk) begin
      if (men[g]) begin
        if (mwe[g]) mem[maddr[g]] <= mwd[g];
        pipe[0] <= mem[maddr[g]];
      end
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mrd[g] = pipe[LAT-1];

    bram_rr_port_arbiter #(.ABITS(10), .DBITS(36), .RD_LATENCY(LAT)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_valid(a_valid), .a_ready(ar[g]), .a_we(a_we), .a_addr(a_addr),
      .a_wdata(a_wdata), .a_rvalid(arv[g]), .a_rdata(ard[g]),
      .b_valid(b_valid), .b_ready(br[g]), .b_we(b_we), .b_addr(b_addr),
      .b_wdata(b_wdata), .b_rvalid(brv[g]), .b_rdata(brd[g]),
      .mem_en(men[g]), .mem_we(mwe[g]), .mem_addr(maddr[g]), .mem_wd(mwd[g]),
      .mem_rd(mrd[g])
    );
  end

  task automatic chk(input string n, input int i, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s lat=%0d cyc=%0d got=%0h want=%0h", n, i + 1, cyc, act, exp);
    end
  endtask

  // Monitor: every response strobe must match the oldest queued expectation
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (arv[i] && brv[i]) chk("both_rvalid", i, 1, 0);
      else if (arv[i] || brv[i]) begin
        if (qs[i].size() == 0) chk("unexpected_rvalid", i, {63'd0, brv[i]}, 64'hdead);
        else begin
          exp_t e;
          e = qs[i].pop_front();
          chk("resp_id", i, {63'd0, brv[i]}, {63'd0, e.id});
          chk("resp_data", i, brv[i] ? brd[i] : ard[i], e.data);
          chk("resp_cycle", i, cyc, e.cyc + i + 1);
        end
      end
    end
  end

  // One cycle of stimulus with hand-computed grant expectations
  task automatic step(input bit av, input bit awe, input int aa, input logic [35:0] awd,
                      input bit bv, input bit bwe, input int ba, input logic [35:0] bwd,
                      input bit ear, input bit ebr, input bit push);
    logic [9:0]  ea;
    logic [35:0] ed;
    bit          ewe;
    a_valid = av; a_we = awe; a_addr = 10'(aa); a_wdata = awd;
    b_valid = bv; b_we = bwe; b_addr = 10'(ba); b_wdata = bwd;
    ea  = ebr ? 10'(ba) : 10'(aa);
    ed  = ebr ? bwd : awd;
    ewe = ebr ? bwe : (ear & awe);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk("a_ready", i, {63'd0, ar[i]}, {63'd0, ear});
      chk("b_ready", i, {63'd0, br[i]}, {63'd0, ebr});
      chk("mem_en", i, {63'd0, men[i]}, {63'd0, ear | ebr});
      chk("mem_we", i, {63'd0, mwe[i]}, {63'd0, ewe});
      chk("mem_addr", i, {54'd0, maddr[i]}, {54'd0, ea});
      chk("mem_wd", i, {28'd0, mwd[i]}, {28'd0, ed});
      if (!rst_n) chk("rvalid_in_reset", i, {62'd0, arv[i], brv[i]}, 0);
    end
    if ((ear || ebr) && ewe) shadow[ea] = ed;
    if ((ear || ebr) && !ewe && push)
      for (int i = 0; i < NI; i++) qs[i].push_back('{id: ebr, data: shadow[ea], cyc: cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input bit push);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, push);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = 36'h100 + 36'(i);
    @(posedge clk); #1;
    // Reset held with both requesting: nothing granted
    rst_n = 0;
    for (int k = 0; k < 3; k++) step(1, 0, 1, 0, 1, 0, 2, 0, 0, 0, 1);
    rst_n = 1;
    // Contention: A first after reset, then strict alternation
    step(1, 0, 1, 0, 1, 0, 2, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 1);
    step(1, 0, 1, 0, 1, 0, 2, 0, 1, 0, 1);
    step(1, 0, 1, 0, 1, 0, 2, 0, 0, 1, 1);
    // Single requester: write then read back
    step(1, 1, 3, 36'h5, 0, 0, 0, 0, 1, 0, 1);
    step(1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 1);
    // Fairness after an uncontended B grant
    step(0, 0, 0, 0, 1, 0, 7, 0, 0, 1, 1);
    step(1, 0, 8, 0, 1, 0, 9, 0, 1, 0, 1);
    step(0, 0, 8, 0, 1, 0, 9, 0, 0, 1, 1);
    // No grant: A's inputs pass through on the RAM bus
    step(0, 0, 42, 36'h77, 0, 0, 5, 36'h99, 0, 0, 1);
    // Back-to-back reads A@4, B@5, A@6
    step(1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1);
    step(0, 0, 0, 0, 1, 0, 5, 0, 0, 1, 1);
    step(1, 0, 6, 0, 0, 0, 0, 0, 1, 0, 1);
    // B writes, A reads the new value
    step(0, 0, 0, 0, 1, 1, 4, 36'hABC, 0, 1, 1);
    step(1, 0, 4, 0, 0, 0, 0, 0, 1, 0, 1);
    idle(1); idle(1); idle(1); idle(1);
    // Reset mid-flight: accepted read is dropped
    step(1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0);
    rst_n = 0;
    idle(0);
    rst_n = 1;
    idle(1);
    idle(1);
    step(1, 0, 2, 0, 1, 0, 3, 0, 1, 0, 1);
    step(0, 0, 2, 0, 1, 0, 3, 0, 0, 1, 1);
    for (int k = 0; k < 8; k++) idle(1);
    for (int i = 0; i < NI; i++) chk("queue_drained", i, qs[i].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bram_rr_port_arbiter.md
Name: bram_rr_port_arbiter

Overview:
Shares one single-port synchronous block RAM port between two requesters (A, B) using round-robin arbitration.
- Each requester issues read/write requests over a valid/ready handshake.
- Read data returns on a per-requester response strobe after a fixed RAM read latency.
- Sits in front of an inferred `block_ram`-style memory whose read data is registered on the same clock edge that samples the address.

Parameters:
- ABITS, 10, address width.
- DBITS, 36, data width.
- RD_LATENCY, 1, cycles from the accepting edge to valid mem_rd; legal values 1 to 4.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst_n  input  1  synchronous reset, active-low.
- a_valid  input  1  requester A request valid.
- a_ready  output  1  requester A request accepted this cycle.
- a_we  input  1  A write (1) / read (0).
- a_addr  input  ABITS  A address.
- a_wdata  input  DBITS  A write data.
- a_rvalid  output  1  A read data valid.
- a_rdata  output  DBITS  A read data.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata: same as the A ports, for requester B.
- mem_en  output  1  RAM port enable.
- mem_we  output  1  RAM write enable.
- mem_addr  output  ABITS  RAM address.
- mem_wd  output  DBITS  RAM write data.
- mem_rd  input  DBITS  RAM registered read data.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-low on rst_n. While rst_n=0:
  - a_ready, b_ready, mem_en, mem_we, a_rvalid, b_rvalid all 0.
  - last_grant is set to B, so A wins the first contention.
  - The response pipeline is cleared.
  - Reset mid-operation drops in-flight reads; no rvalid is produced for them.
- Handshake: a transfer occurs on an edge where x_valid=1 and x_ready=1.
  - A requester must hold valid, we, addr and wdata stable until accepted.
  - valid must not depend on ready.
  - ready is combinational from the valid inputs and last_grant, and is never 1 for both requesters in the same cycle.
- Arbitration, per cycle, with rst_n=1:
  - Only one requester valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: no grant; mem_en=0 and mem_we=0.
  - last_grant updates to the granted requester on every grant, including uncontended grants.
  - With both valid continuously, grants strictly alternate; starvation bound is 1 cycle.
- RAM drive: combinational from the granted request in the grant cycle.
  - mem_en=1, mem_we=granted we, mem_addr=granted addr, mem_wd=granted wdata.
  - When no grant: mem_addr and mem_wd hold the value of requester A's inputs (don't-care, but deterministic).
- Response pipeline: RD_LATENCY-deep shift register of {read_valid, id}, loaded at each accepting edge.
  - read_valid = accepted & ~we; id = 0 for A, 1 for B.
  - In the cycle the last stage holds read_valid=1, the matching x_rvalid is 1 for exactly one cycle and x_rdata=mem_rd. The other requester's rvalid is 0.
  - Response latency = RD_LATENCY cycles after the accepting edge.
  - Writes produce no rvalid; the ready handshake is the write acknowledge.
  - Read responses return in acceptance order; there is no response backpressure, so the requester must sink them.
  - Back-to-back accepts give one response per cycle; throughput is 1 request/cycle total.
- Read-during-write: a read to an address written in an earlier accepted cycle returns the new data, because the RAM port is serialized. Same-cycle conflicts are impossible, since only one port access occurs per cycle.
- x_rdata when x_rvalid=0: passes mem_rd through; don't-care, must not be relied on.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with a_valid=b_valid=1 -> a_ready=b_ready=0, mem_en=0, no rvalid. Release -> first cycle grants A.
- Single requester: A writes 0x5 to addr 3, then reads addr 3 on the next cycle with RD_LATENCY=1 -> a_ready=1 both cycles; a_rvalid=1 one cycle after the read accept with a_rdata=0x5; b_rvalid stays 0.
- Contention: A and B both hold reads (addrs 1 and 2) valid for 4 cycles -> grants A,B,A,B; mem_addr sequence 1,2,1,2; rvalids alternate, each with the correct data.
- Fairness after an uncontended grant: B alone is granted, then both valid next cycle -> A granted.
- Latency: RD_LATENCY=3, back-to-back reads A@4, B@5, A@6 -> rvalids on cycles +3,+4,+5 with correct ids and data, in order.
- Reset mid-flight: RD_LATENCY=2, A read accepted, then rst_n=0 on the next cycle -> no a_rvalid; after release, normal operation resumes.
